conway_serial_controller: RTL and testbench
===========================================

Name: conway_serial_controller

Overview:
Host-side sequencer for the serial 8x8 Life core. It accepts whole-grid commands over a valid/ready interface and drives the core's 2-bit mode and serial data_in pins. Commands are LOAD a 64-bit grid, RUN N generations, and READ the grid back. READ results are returned on a parallel response port. The block sits between the host logic and the core's serial pins and guarantees that every load and every read is exactly DATA_SIZE shift cycles, which the core requires.

Parameters:
DATA_SIZE, 64, grid bits per load/read (GRID_WIDTH*GRID_HEIGHT)
GEN_WIDTH, 16, width of the per-command generation count and of the generation total

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  opcode: 00 LOAD, 01 RUN, 10 READ, 11 reserved
cmd_grid  input  DATA_SIZE  grid to load; used by LOAD only
cmd_gens  input  GEN_WIDTH  generations to run; used by RUN only
rsp_valid  output  1  READ result available
rsp_ready  input  1  host accepts the result
rsp_grid  output  DATA_SIZE  grid read from the core
cmd_err  output  1  one-cycle pulse when a reserved opcode is accepted
gen_total  output  GEN_WIDTH  generations run since the last LOAD; saturating
busy  output  1  high in any state other than IDLE
core_mode  output  2  drives the core's mode input (00 load, 01 run, 10 output, 11 stop)
core_data_in  output  1  drives the core's serial data_in
core_data_out  input  1  the core's serial data_out

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, cmd_ready=1, core_mode=11, core_data_in=0, rsp_valid=0, rsp_grid=0, cmd_err=0, gen_total=0, busy=0.
- States: IDLE, LOAD, RUN, READ, RESP.
- cmd_ready=1 only in IDLE. A command is accepted on an edge where cmd_valid && cmd_ready. The controller leaves IDLE on the next cycle.
- IDLE: core_mode=11, so the core holds its state.
- Accepting LOAD: latches cmd_grid into the shift register and enters LOAD.
  - LOAD lasts exactly DATA_SIZE cycles with core_mode=00.
  - core_data_in presents cmd_grid[DATA_SIZE-1] in the first cycle, then descending bits, ending with bit 0.
  - bit_cnt counts 0..DATA_SIZE-1.
  - Exit goes to IDLE; core_mode=11 is presented the cycle after the last bit.
  - gen_total clears to 0 on entry to LOAD.
- Accepting RUN with cmd_gens=N:
  - N>0: enters RUN, which lasts exactly N cycles with core_mode=01, then IDLE.
  - gen_total increments by 1 per RUN cycle and saturates at 2^GEN_WIDTH-1.
  - N=0: no RUN cycle occurs. The controller returns to IDLE (cmd_ready=1) on the cycle after acceptance, and core_mode stays 11.
- Accepting READ: enters READ, which lasts exactly DATA_SIZE cycles with core_mode=10.
  - core_data_out is sampled on the rising edge that ends each READ cycle.
  - The sampled bit shifts into the capture register from the LSB side. The first sampled bit therefore ends at rsp_grid[DATA_SIZE-1].
  - Net effect: LOAD of G followed by READ returns G.
  - After the last bit: state RESP, rsp_valid=1, rsp_grid stable.
- RESP: hold until rsp_valid && rsp_ready, then IDLE. rsp_valid falls on that edge.
  - A READ result that is never consumed stalls the controller. No new command is accepted.
  - READ does not change gen_total.
- Accepting op 11: cmd_err=1 for exactly one cycle (the cycle after acceptance). The controller stays in IDLE, the core is untouched, and cmd_ready stays 1.
- cmd_* inputs are ignored while cmd_ready=0. cmd_grid and cmd_gens are captured only at acceptance; later changes have no effect.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at reset values. Any partial shift is abandoned.
  - The core's grid contents are then undefined to the host, which must re-LOAD.
  - A pending RESP is discarded.
- Back-to-back commands: a new command can be accepted in the first IDLE cycle after completion. The minimum gap between shift phases is one cycle with core_mode=11.

Test Plan:
- Reset, then LOAD cmd_grid=64'h8000_0000_0000_0001 -> cmd_ready falls the cycle after acceptance; core_mode=00 for exactly 64 cycles; core_data_in=1 on cycles 1 and 64 and 0 elsewhere; then core_mode=11, cmd_ready=1, gen_total=0.
- Against a 64-bit FIFO shift-register model of the core: LOAD 64'hDEAD_BEEF_0123_4567, then READ -> core_mode=10 for exactly 64 cycles; rsp_valid=1 with rsp_grid=64'hDEAD_BEEF_0123_4567.
- RUN cmd_gens=5 after LOAD -> core_mode=01 for exactly 5 cycles; gen_total=5. RUN cmd_gens=0 -> no 01 cycle, gen_total unchanged, cmd_ready=1 next cycle. RUN 3 more -> gen_total=8. A new LOAD -> gen_total=0.
- READ with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_grid stable; cmd_ready=0 even with cmd_valid=1. Then rsp_ready=1 -> rsp_valid falls and cmd_ready=1 the next cycle.
- cmd_op=11 accepted -> cmd_err high exactly one cycle; core_mode stays 11; state stays IDLE.
- Assert reset at LOAD bit 30 -> core_mode=11, busy=0, cmd_ready=1 immediately; then a full LOAD followed by READ returns the newly loaded grid.
- GEN_WIDTH=4 build: RUN 20 -> gen_total saturates at 15.

Source files
------------

// File: rtl/conway_serial_controller.sv
// Host-side sequencer for the serial 8x8 Life core: turns whole-grid LOAD/RUN/READ
// commands into exact-length mode/data_in sequences on the core's serial pins.
module conway_serial_controller #(
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned GEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [DATA_SIZE-1:0] cmd_grid,
   input  logic [GEN_WIDTH-1:0] cmd_gens,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_SIZE-1:0] rsp_grid,
   output logic                 cmd_err,
   output logic [GEN_WIDTH-1:0] gen_total,
   output logic                 busy,
   output logic [1:0]           core_mode,
   output logic                 core_data_in,
   input  logic                 core_data_out
);

   localparam int unsigned CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;

   localparam logic [1:0] MODE_LOAD = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_OUT  = 2'b10;
   localparam logic [1:0] MODE_STOP = 2'b11;

   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_SIZE - 1);
   localparam logic [GEN_WIDTH-1:0] GEN_MAX  = {GEN_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_READ,
      S_RESP
   } state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
   logic [GEN_WIDTH-1:0] gen_rem, gen_rem_d;
   logic [DATA_SIZE-1:0] shreg, shreg_d;

   logic                 cmd_ready_d;
   logic                 rsp_valid_d;
   logic [DATA_SIZE-1:0] rsp_grid_d;
   logic                 cmd_err_d;
   logic [GEN_WIDTH-1:0] gen_total_d;
   logic                 busy_d;
   logic [1:0]           core_mode_d;
   logic                 core_data_in_d;

   // State, counters, shift register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         gen_rem      <= '0;
         shreg        <= '0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_grid     <= '0;
         cmd_err      <= 1'b0;
         gen_total    <= '0;
         busy         <= 1'b0;
         core_mode    <= MODE_STOP;
         core_data_in <= 1'b0;
      end else begin
         state        <= state_d;
         bit_cnt      <= bit_cnt_d;
         gen_rem      <= gen_rem_d;
         shreg        <= shreg_d;
         cmd_ready    <= cmd_ready_d;
         rsp_valid    <= rsp_valid_d;
         rsp_grid     <= rsp_grid_d;
         cmd_err      <= cmd_err_d;
         gen_total    <= gen_total_d;
         busy         <= busy_d;
         core_mode    <= core_mode_d;
         core_data_in <= core_data_in_d;
      end
   end

   // Next state and next output values; outputs are computed one cycle ahead.
   always_comb begin
      state_d        = state;
      bit_cnt_d      = bit_cnt;
      gen_rem_d      = gen_rem;
      shreg_d        = shreg;
      cmd_ready_d    = cmd_ready;
      rsp_valid_d    = rsp_valid;
      rsp_grid_d     = rsp_grid;
      cmd_err_d      = 1'b0;
      gen_total_d    = gen_total;
      busy_d         = busy;
      core_mode_d    = core_mode;
      core_data_in_d = 1'b0;

      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               case (cmd_op)
                  OP_LOAD: begin
                     state_d        = S_LOAD;
                     bit_cnt_d      = '0;
                     core_data_in_d = cmd_grid[DATA_SIZE-1];
                     shreg_d        = {cmd_grid[DATA_SIZE-2:0], 1'b0};
                     core_mode_d    = MODE_LOAD;
                     cmd_ready_d    = 1'b0;
                     busy_d         = 1'b1;
                     gen_total_d    = '0;
                  end
                  OP_RUN: begin
                     // A zero-generation RUN is a no-op that never leaves IDLE.
                     if (cmd_gens != '0) begin
                        state_d     = S_RUN;
                        gen_rem_d   = cmd_gens;
                        core_mode_d = MODE_RUN;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                     end
                  end
                  OP_READ: begin
                     state_d     = S_READ;
                     bit_cnt_d   = '0;
                     shreg_d     = '0;
                     core_mode_d = MODE_OUT;
                     cmd_ready_d = 1'b0;
                     busy_d      = 1'b1;
                  end
                  default: begin
                     cmd_err_d = 1'b1;
                  end
               endcase
            end
         end

         S_LOAD: begin
            if (bit_cnt == LAST_BIT) begin
               state_d     = S_IDLE;
               core_mode_d = MODE_STOP;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end else begin
               bit_cnt_d      = bit_cnt + CNT_W'(1);
               core_data_in_d = shreg[DATA_SIZE-1];
               shreg_d        = {shreg[DATA_SIZE-2:0], 1'b0};
            end
         end

         S_RUN: begin
            if (gen_total != GEN_MAX) begin
               gen_total_d = gen_total + GEN_WIDTH'(1);
            end
            if (gen_rem == GEN_WIDTH'(1)) begin
               state_d     = S_IDLE;
               core_mode_d = MODE_STOP;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end else begin
               gen_rem_d = gen_rem - GEN_WIDTH'(1);
            end
         end

         S_READ: begin
            // First sampled bit ends up in the MSB after DATA_SIZE shifts.
            shreg_d = {shreg[DATA_SIZE-2:0], core_data_out};
            if (bit_cnt == LAST_BIT) begin
               state_d     = S_RESP;
               rsp_grid_d  = {shreg[DATA_SIZE-2:0], core_data_out};
               rsp_valid_d = 1'b1;
               core_mode_d = MODE_STOP;
            end else begin
               bit_cnt_d = bit_cnt + CNT_W'(1);
            end
         end

         S_RESP: begin
            if (rsp_valid && rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
         end

         default: begin
            state_d     = S_IDLE;
            core_mode_d = MODE_STOP;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_conway_serial_controller.sv
// Self-checking bench for conway_serial_controller with a FIFO model of the core.
module tb_conway_serial_controller;

   localparam int unsigned DS = 64;
   localparam int unsigned GW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [DS-1:0] cmd_grid = '0;
   logic [GW-1:0] cmd_gens = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DS-1:0] rsp_grid;
   logic          cmd_err;
   logic [GW-1:0] gen_total;
   logic          busy;
   logic [1:0]    core_mode;
   logic          core_data_in;
   logic          core_data_out;

   // Second instance with a narrow generation counter for saturation.
   logic          c4_valid = 1'b0;
   logic          c4_ready;
   logic [1:0]    c4_op = 2'b01;
   logic [DS-1:0] c4_grid = '0;
   logic [3:0]    c4_gens = '0;
   logic          c4_rsp_valid;
   logic [DS-1:0] c4_rsp_grid;
   logic          c4_err;
   logic [3:0]    c4_total;
   logic          c4_busy;
   logic [1:0]    c4_mode;
   logic          c4_data_in;
   logic          c4_data_out = 1'b0;
   logic          c4_rsp_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conway_serial_controller #(.DATA_SIZE(DS), .GEN_WIDTH(GW)) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_grid(cmd_grid), .cmd_gens(cmd_gens),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_grid(rsp_grid),
      .cmd_err(cmd_err), .gen_total(gen_total), .busy(busy),
      .core_mode(core_mode), .core_data_in(core_data_in), .core_data_out(core_data_out)
   );

   conway_serial_controller #(.DATA_SIZE(DS), .GEN_WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_op(c4_op),
      .cmd_grid(c4_grid), .cmd_gens(c4_gens),
      .rsp_valid(c4_rsp_valid), .rsp_ready(c4_rsp_ready), .rsp_grid(c4_rsp_grid),
      .cmd_err(c4_err), .gen_total(c4_total), .busy(c4_busy),
      .core_mode(c4_mode), .core_data_in(c4_data_in), .core_data_out(c4_data_out)
   );

   // Core model: FIFO shift register; loads from data_in, rotates out on output mode.
   logic [DS-1:0] core_mem = '0;
   assign core_data_out = core_mem[DS-1];
   always @(posedge clk) begin
      if (core_mode == 2'b00) core_mem <= {core_mem[DS-2:0], core_data_in};
      else if (core_mode == 2'b10) core_mem <= {core_mem[DS-2:0], core_mem[DS-1]};
   end

   typedef struct {
      logic [1:0]    op;
      logic [DS-1:0] grid;
      logic [GW-1:0] gens;
      int            cycles;
      logic [GW-1:0] total;
      logic          err;
      logic [DS-1:0] rsp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Issue one command, watch the whole operation, and compare against the record.
   task automatic exec(input vec_t v, input string tag);
      int active, wrong, cyc;
      logic [DS-1:0] sent;
      logic [1:0] em;
      em = (v.op == 2'b10) ? 2'b10 : (v.op == 2'b01) ? 2'b01 : 2'b00;
      active = 0; wrong = 0; cyc = 0; sent = '0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_grid = v.grid; cmd_gens = v.gens;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_grid = '1; cmd_gens = '1;
      check({tag, " err_first"}, DS'(cmd_err), DS'(v.err));
      check({tag, " ready_first"}, DS'(cmd_ready), DS'(v.cycles == 0));
      check({tag, " busy_first"}, DS'(busy), DS'(v.cycles != 0));
      while (!cmd_ready && !rsp_valid && cyc < 300) begin
         if (core_mode != 2'b11) active++;
         if (core_mode != 2'b11 && core_mode != em) wrong++;
         if (core_mode == 2'b00) sent = {sent[DS-2:0], core_data_in};
         cyc++;
         @(negedge clk);
      end
      check({tag, " timeout"}, DS'(cyc < 300), DS'(1));
      check({tag, " active_cycles"}, DS'(active), DS'(v.cycles));
      check({tag, " wrong_mode"}, DS'(wrong), '0);
      check({tag, " mode_after"}, DS'(core_mode), DS'(2'b11));
      if (v.op == 2'b00) check({tag, " load_bits"}, sent, v.grid);
      if (v.op == 2'b10) begin
         check({tag, " rsp_valid"}, DS'(rsp_valid), DS'(1));
         check({tag, " rsp_grid"}, rsp_grid, v.rsp);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         check({tag, " rsp_drop"}, DS'(rsp_valid), '0);
      end else begin
         @(negedge clk);
      end
      check({tag, " err_after"}, DS'(cmd_err), '0);
      check({tag, " ready_after"}, DS'(cmd_ready), DS'(1));
      check({tag, " busy_after"}, DS'(busy), '0);
      check({tag, " gen_total"}, DS'(gen_total), DS'(v.total));
   endtask

   // RUN on the narrow instance; count run cycles and check the saturated total.
   task automatic run4(input logic [3:0] gens, input int exp_cnt, input logic [3:0] exp_total);
      int cnt, cyc;
      cnt = 0; cyc = 0;
      @(negedge clk);
      c4_valid = 1'b1; c4_op = 2'b01; c4_gens = gens;
      @(negedge clk);
      c4_valid = 1'b0;
      while (!c4_ready && cyc < 100) begin
         if (c4_mode == 2'b01) cnt++;
         cyc++;
         @(negedge clk);
      end
      check("sat timeout", DS'(cyc < 100), DS'(1));
      check("sat run_cycles", DS'(cnt), DS'(exp_cnt));
      check("sat gen_total", DS'(c4_total), DS'(exp_total));
   endtask

   initial begin
      logic [DS-1:0] held;
      int cyc;
      //         op     grid                     gens  cyc total err rsp
      vecs[0] = '{2'b00, 64'h8000_0000_0000_0001, 16'd0, 64, 16'd0, 1'b0, 64'h0};
      vecs[1] = '{2'b00, 64'hDEAD_BEEF_0123_4567, 16'd0, 64, 16'd0, 1'b0, 64'h0};
      vecs[2] = '{2'b10, 64'h0,                   16'd0, 64, 16'd0, 1'b0, 64'hDEAD_BEEF_0123_4567};
      vecs[3] = '{2'b01, 64'h0,                   16'd5,  5, 16'd5, 1'b0, 64'h0};
      vecs[4] = '{2'b01, 64'h0,                   16'd0,  0, 16'd5, 1'b0, 64'h0};
      vecs[5] = '{2'b01, 64'h0,                   16'd3,  3, 16'd8, 1'b0, 64'h0};
      vecs[6] = '{2'b10, 64'h0,                   16'd0, 64, 16'd8, 1'b0, 64'hDEAD_BEEF_0123_4567};
      vecs[7] = '{2'b11, 64'hFFFF_0000_FFFF_0000, 16'd9,  0, 16'd8, 1'b1, 64'h0};
      vecs[8] = '{2'b00, 64'h0123_4567_89AB_CDEF, 16'd0, 64, 16'd0, 1'b0, 64'h0};
      vecs[9] = '{2'b10, 64'h0,                   16'd0, 64, 16'd0, 1'b0, 64'h0123_4567_89AB_CDEF};

      repeat (3) @(negedge clk);
      check("rst cmd_ready", DS'(cmd_ready), DS'(1));
      check("rst core_mode", DS'(core_mode), DS'(2'b11));
      check("rst data_in", DS'(core_data_in), '0);
      check("rst rsp_valid", DS'(rsp_valid), '0);
      check("rst rsp_grid", rsp_grid, '0);
      check("rst cmd_err", DS'(cmd_err), '0);
      check("rst gen_total", DS'(gen_total), '0);
      check("rst busy", DS'(busy), '0);
      check("rst4 outs", DS'({c4_rsp_valid, c4_err, c4_busy, c4_data_in, c4_total}), '0);
      check("rst4 rsp_grid", c4_rsp_grid, '0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) exec(vecs[i], $sformatf("vec%0d", i));

      // Unconsumed READ stalls the controller and ignores new commands.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10;
      @(negedge clk);
      cmd_op = 2'b00; cmd_grid = 64'hFFFF_FFFF_FFFF_FFFF;
      cyc = 0;
      while (!rsp_valid && cyc < 100) begin cyc++; @(negedge clk); end
      check("stall reach_resp", DS'(rsp_valid), DS'(1));
      held = rsp_grid;
      check("stall grid", held, 64'h0123_4567_89AB_CDEF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("stall%0d valid", i), DS'(rsp_valid), DS'(1));
         check($sformatf("stall%0d grid", i), rsp_grid, held);
         check($sformatf("stall%0d ready", i), DS'(cmd_ready), '0);
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("stall release valid", DS'(rsp_valid), '0);
      check("stall release ready", DS'(cmd_ready), DS'(1));
      check("stall no_load mode", DS'(core_mode), DS'(2'b11));

      // Reset in the middle of a LOAD.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_grid = 64'hAAAA_AAAA_AAAA_AAAA;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (30) @(negedge clk);
      check("midrst in_load", DS'(core_mode), DS'(2'b00));
      reset = 1'b1;
      #1;
      check("midrst mode", DS'(core_mode), DS'(2'b11));
      check("midrst busy", DS'(busy), '0);
      check("midrst ready", DS'(cmd_ready), DS'(1));
      check("midrst data_in", DS'(core_data_in), '0);
      @(negedge clk);
      reset = 1'b0;
      exec('{2'b00, 64'h5A5A_0F0F_C3C3_9669, 16'd0, 64, 16'd0, 1'b0, 64'h0}, "reload");
      exec('{2'b10, 64'h0, 16'd0, 64, 16'd0, 1'b0, 64'h5A5A_0F0F_C3C3_9669}, "reread");

      // Narrow generation counter: 15 + 5 saturates at 15.
      run4(4'd15, 15, 4'd15);
      run4(4'd5, 5, 4'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
